// File: rtl/board_state.sv
// board_state: 8x8 chess board register file with init/move sequencing FSM.
// Optional BOARD_OWNERSHIP_CHECK_EN rejects moves of empty/foreign pieces or onto own pieces.
module board_state (
    input  logic       clk,
    input  logic       resetn,
    input  logic       init_req,
    input  logic       move_req,
    input  logic [2:0] src_x,
    input  logic [2:0] src_y,
    input  logic [2:0] dst_x,
    input  logic [2:0] dst_y,
    input  logic [2:0] view_x,
    input  logic [2:0] view_y,
    output logic [3:0] piece_read,
    output logic       current_player,
    output logic       busy,
    output logic       init_done,
    output logic       move_done,
    output logic       move_err,
    output logic       start_render_board,
    output logic [3:0] captured
);
    typedef enum logic [2:0] {
        S_IDLE, S_INIT_FILL, S_MOVE_CHECK, S_MOVE_WRITE, S_MOVE_CLEAR, S_MOVE_ERR, S_DONE
    } state_t;

    localparam logic [3:0] BACK_ROW [8] = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};

    state_t     r_state;
    logic [3:0] r_board [64];
    logic [5:0] r_cnt;
    logic [5:0] r_src;
    logic [5:0] r_dst;
    logic [3:0] w_src_pc;
    logic [3:0] w_dst_pc;
    logic       w_reject;

    // White back row reuses the black codes shifted by six.
    function automatic logic [3:0] f_init_piece(input logic [5:0] idx);
        logic [3:0] back;
        back = BACK_ROW[idx[2:0]];
        return idx[5:3] == 3'd0 ? back :
               idx[5:3] == 3'd1 ? 4'd1 :
               idx[5:3] == 3'd6 ? 4'd7 :
               idx[5:3] == 3'd7 ? back + 4'd6 : 4'd0;
    endfunction

    assign w_src_pc = r_board[r_src];
    assign w_dst_pc = r_board[r_dst];
    assign busy     = r_state != S_IDLE;

`ifdef BOARD_OWNERSHIP_CHECK_EN
    function automatic logic f_is_black(input logic [3:0] pc);
        return pc != 4'd0 && pc <= 4'd6;
    endfunction

    assign w_reject = w_src_pc == 4'd0 || f_is_black(w_src_pc) != current_player ||
                      (w_dst_pc != 4'd0 && f_is_black(w_dst_pc) == current_player);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) move_err <= 1'b0;
        else         move_err <= r_state == S_MOVE_CHECK && w_reject;
    end
`else
    assign w_reject = 1'b0;
    assign move_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state            <= S_IDLE;
            r_cnt              <= '0;
            r_src              <= '0;
            r_dst              <= '0;
            piece_read         <= '0;
            current_player     <= 1'b0;
            captured           <= '0;
            init_done          <= 1'b0;
            move_done          <= 1'b0;
            start_render_board <= 1'b0;
            for (int i = 0; i < 64; i++) r_board[i] <= '0;
        end else begin
            piece_read         <= r_board[{view_y, view_x}];
            init_done          <= 1'b0;
            move_done          <= 1'b0;
            start_render_board <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (init_req) begin
                        r_state <= S_INIT_FILL;
                        r_cnt   <= '0;
                    end else if (move_req) begin
                        r_state <= S_MOVE_CHECK;
                        r_src   <= {src_y, src_x};
                        r_dst   <= {dst_y, dst_x};
                    end
                end
                S_INIT_FILL: begin
                    r_board[r_cnt] <= f_init_piece(r_cnt);
                    r_cnt          <= r_cnt + 6'd1;
                    if (r_cnt == 6'd63) begin
                        r_state            <= S_DONE;
                        current_player     <= 1'b0;
                        captured           <= '0;
                        init_done          <= 1'b1;
                        start_render_board <= 1'b1;
                    end
                end
                S_MOVE_CHECK: r_state <= w_reject ? S_MOVE_ERR : S_MOVE_WRITE;
                S_MOVE_WRITE: begin
                    r_board[r_dst] <= w_src_pc;
                    captured       <= w_dst_pc;
                    r_state        <= S_MOVE_CLEAR;
                end
                S_MOVE_CLEAR: begin
                    r_board[r_src]     <= '0;
                    current_player     <= ~current_player;
                    move_done          <= 1'b1;
                    start_render_board <= 1'b1;
                    r_state            <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_state.sv
// tb_board_state: directed checks of board_state reset, init, move timing, arbitration and abort.
module tb_board_state;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       init_req = 1'b0;
    logic       move_req = 1'b0;
    logic [2:0] src_x = '0, src_y = '0, dst_x = '0, dst_y = '0, view_x = '0, view_y = '0;
    logic [3:0] piece_read;
    logic       current_player;
    logic       busy;
    logic       init_done;
    logic       move_done;
    logic       move_err;
    logic       start_render_board;
    logic [3:0] captured;

    int n_pass = 0;
    int n_total = 0;
    int mb [64];
    int m_player = 0;
    int m_captured = 0;
    int row0 [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    int row7 [8] = '{10, 8, 9, 11, 12, 9, 8, 10};

    board_state dut (
        .clk(clk), .resetn(resetn), .init_req(init_req), .move_req(move_req),
        .src_x(src_x), .src_y(src_y), .dst_x(dst_x), .dst_y(dst_y),
        .view_x(view_x), .view_y(view_y), .piece_read(piece_read),
        .current_player(current_player), .busy(busy), .init_done(init_done),
        .move_done(move_done), .move_err(move_err),
        .start_render_board(start_render_board), .captured(captured)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic rd(input int x, input int y, input int exp);
        view_x = 3'(x);
        view_y = 3'(y);
        @(negedge clk);
        chk($sformatf("sq(%0d,%0d)", x, y), int'(piece_read), exp);
    endtask

    task automatic check_board();
        for (int i = 0; i < 64; i++) rd(i % 8, i / 8, mb[i]);
    endtask

    function automatic bit legal(input int sp, input int dp);
`ifdef BOARD_OWNERSHIP_CHECK_EN
        bit sb, db;
        sb = sp >= 1 && sp <= 6;
        db = dp >= 1 && dp <= 6;
        return sp != 0 && int'(sb) == m_player && !(dp != 0 && int'(db) == m_player);
`else
        return 1'b1;
`endif
    endfunction

    task automatic do_move(input int sx, input int sy, input int dx, input int dy);
        int sp, dp, done_c, err_c, busy_n, srb_c;
        bit ok;
        sp = mb[sy * 8 + sx];
        dp = mb[dy * 8 + dx];
        ok = legal(sp, dp);
        src_x = 3'(sx); src_y = 3'(sy); dst_x = 3'(dx); dst_y = 3'(dy);
        move_req = 1'b1;
        done_c = 0; err_c = 0; busy_n = 0; srb_c = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            move_req = 1'b0;
            if (busy) busy_n++;
            if (move_done) done_c = c;
            if (move_err) err_c = c;
            if (start_render_board) srb_c = c;
        end
        chk("move_done_cycle", done_c, ok ? 4 : 0);
        chk("move_err_cycle", err_c, ok ? 0 : 2);
        chk("busy_cycles", busy_n, ok ? 4 : 2);
        chk("render_cycle", srb_c, ok ? 4 : 0);
        if (ok) begin
            m_captured = dp;
            mb[dy * 8 + dx] = sp;
            mb[sy * 8 + sx] = 0;
            m_player ^= 1;
        end
        chk("captured", int'(captured), m_captured);
        chk("player", int'(current_player), m_player);
        check_board();
    endtask

    initial begin
        int init_c, init_n, mdone_n, srb_c;
        for (int i = 0; i < 64; i++) mb[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_piece_read", int'(piece_read), 0);
        chk("rst_player", int'(current_player), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_captured", int'(captured), 0);
        chk("rst_pulses", int'({init_done, move_done, move_err, start_render_board}), 0);
        resetn = 1'b1;
        @(negedge clk);
        check_board();

        // init and move requested together, then a second move mid-init
        init_req = 1'b1;
        move_req = 1'b1;
        src_x = 3'd4; src_y = 3'd6; dst_x = 3'd4; dst_y = 3'd4;
        init_c = 0; init_n = 0; mdone_n = 0; srb_c = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c == 1) chk("init_busy", int'(busy), 1);
            if (init_done) begin init_c = c; init_n++; end
            if (move_done) mdone_n++;
            if (start_render_board) srb_c = c;
            init_req = 1'b0;
            move_req = c == 3;
        end
        chk("init_done_cycle", init_c, 65);
        chk("init_done_count", init_n, 1);
        chk("init_render_cycle", srb_c, 65);
        chk("ignored_moves", mdone_n, 0);
        chk("init_idle", int'(busy), 0);
        chk("init_player", int'(current_player), 0);
        chk("init_captured", int'(captured), 0);
        for (int x = 0; x < 8; x++) begin
            mb[x] = row0[x];
            mb[8 + x] = 1;
            mb[48 + x] = 7;
            mb[56 + x] = row7[x];
        end
        rd(0, 0, 4);
        rd(4, 0, 6);
        rd(3, 7, 11);
        rd(5, 6, 7);
        rd(2, 3, 0);
        check_board();

        do_move(0, 1, 0, 2);
        do_move(4, 6, 4, 4);
        do_move(3, 0, 3, 6);
        do_move(6, 7, 6, 7);

        // reset while the move is in S_MOVE_WRITE
        src_x = 3'd1; src_y = 3'd6; dst_x = 3'd1; dst_y = 3'd5;
        move_req = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(move_done), 0);
        chk("abort_piece_read", int'(piece_read), 0);
        resetn = 1'b1;
        mdone_n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (move_done) mdone_n++;
        end
        chk("abort_no_done", mdone_n, 0);
        chk("abort_player", int'(current_player), 0);
        for (int i = 0; i < 64; i++) mb[i] = 0;
        check_board();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
